// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side view of the hazard/forwarding unit: register fields, write enables,
// branch resolution in, operand selects, stage enables, flushes and event counters out.
interface hazard_forward_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic [4:0]       EX_Rs;
    logic [4:0]       EX_Rt;
    logic             ID_EX_MemRead;
    logic [4:0]       MEM_Rd;
    logic             EX_MEM_RegWrite;
    logic [4:0]       WB_Rd;
    logic             MEM_WB_RegWrite;
    logic             MEM_PCSrc;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic             PC_write;
    logic             IF_ID_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [1:0]       state;

    modport master (
        output ID_Rs, ID_Rt, EX_Rs, EX_Rt, ID_EX_MemRead, MEM_Rd, EX_MEM_RegWrite,
               WB_Rd, MEM_WB_RegWrite, MEM_PCSrc,
        input  ForwardA, ForwardB, PC_write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
               ID_EX_Flush, EX_MEM_Flush, stall_count, flush_count, state
    );

    modport slave (
        input  ID_Rs, ID_Rt, EX_Rs, EX_Rt, ID_EX_MemRead, MEM_Rd, EX_MEM_RegWrite,
               WB_Rd, MEM_WB_RegWrite, MEM_PCSrc,
        output ForwardA, ForwardB, PC_write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
               ID_EX_Flush, EX_MEM_Flush, stall_count, flush_count, state
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Five-stage pipeline hazard unit: EX operand forwarding, load-use stall, taken-branch
// flush with a one-cycle shadow, and saturating stall/flush event counters.
module hazard_forward_unit #(
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    hazard_forward_unit_if.slave bus
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StShadow = 2'b01,
        StHold   = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             luh;
    logic             flush;
    logic             bubble;
    logic             pc_write;
    logic             if_id_write;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // EX/MEM result is newer than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] mem_rd,
                                           input logic mem_we, input logic [4:0] wb_rd,
                                           input logic wb_we);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        bus.ForwardA = fwd_sel(bus.EX_Rs, bus.MEM_Rd, bus.EX_MEM_RegWrite, bus.WB_Rd,
                               bus.MEM_WB_RegWrite);
        bus.ForwardB = fwd_sel(bus.EX_Rt, bus.MEM_Rd, bus.EX_MEM_RegWrite, bus.WB_Rd,
                               bus.MEM_WB_RegWrite);
    end

    assign luh = bus.ID_EX_MemRead && (bus.EX_Rt != 5'd0) &&
                 ((bus.EX_Rt == bus.ID_Rs) || (bus.EX_Rt == bus.ID_Rt));

    always_comb begin
        state_d     = state_q;
        flush       = 1'b0;
        bubble      = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        case (state_q)
            StRun: begin
                if (bus.MEM_PCSrc) begin
                    flush   = 1'b1;
                    state_d = StShadow;
                end else if (luh) begin
                    bubble      = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    state_d     = StHold;
                end
            end
            // The stalled load has moved on (HOLD) or IF/ID holds a flushed NOP (SHADOW):
            // no load-use check, but a taken branch still flushes.
            StHold, StShadow: begin
                if (bus.MEM_PCSrc) begin
                    flush   = 1'b1;
                    state_d = StShadow;
                end else begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        // Reset must mask control outputs even if branch/load inputs are active.
        if (!rst_n) begin
            flush       = 1'b0;
            bubble      = 1'b0;
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (bubble && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (flush && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    always_comb begin
        bus.PC_write     = pc_write;
        bus.IF_ID_Write  = if_id_write;
        bus.ID_EX_Bubble = bubble;
        bus.IF_ID_Flush  = flush;
        bus.ID_EX_Flush  = flush;
        bus.EX_MEM_Flush = flush;
        bus.stall_count  = stall_count_q;
        bus.flush_count  = flush_count_q;
        bus.state        = state_q;
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed vectors with literal expectations plus a
// per-cycle comparison against a rule-level model (16-bit and 4-bit counter instances).
module tb_hazard_forward_unit;

    localparam int PH_RUN    = 0;
    localparam int PH_SHADOW = 1;
    localparam int PH_HOLD   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    hazard_forward_unit_if #(.CNT_W(16)) bus ();
    hazard_forward_unit_if #(.CNT_W(4))  bus4 ();

    hazard_forward_unit #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    hazard_forward_unit #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    assign bus4.ID_Rs           = bus.ID_Rs;
    assign bus4.ID_Rt           = bus.ID_Rt;
    assign bus4.EX_Rs           = bus.EX_Rs;
    assign bus4.EX_Rt           = bus.EX_Rt;
    assign bus4.ID_EX_MemRead   = bus.ID_EX_MemRead;
    assign bus4.MEM_Rd          = bus.MEM_Rd;
    assign bus4.EX_MEM_RegWrite = bus.EX_MEM_RegWrite;
    assign bus4.WB_Rd           = bus.WB_Rd;
    assign bus4.MEM_WB_RegWrite = bus.MEM_WB_RegWrite;
    assign bus4.MEM_PCSrc       = bus.MEM_PCSrc;

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int phase;
    int m_stall;
    int m_flush;
    int m_stall4;
    int m_flush4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (bus.EX_MEM_RegWrite && bus.MEM_Rd != 0 && bus.MEM_Rd == src) return 2'b10;
        if (bus.MEM_WB_RegWrite && bus.WB_Rd != 0 && bus.WB_Rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_luh();
        return bus.ID_EX_MemRead && bus.EX_Rt != 0 &&
               (bus.EX_Rt == bus.ID_Rs || bus.EX_Rt == bus.ID_Rt);
    endfunction

    function automatic logic m_flush_now();
        return rst_n && bus.MEM_PCSrc;
    endfunction

    function automatic logic m_stall_now();
        return rst_n && !bus.MEM_PCSrc && phase == PH_RUN && m_luh();
    endfunction

    function automatic int sat_inc(input int v, input int w);
        return (v < (1 << w) - 1) ? v + 1 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= PH_RUN;
            m_stall  <= 0;
            m_flush  <= 0;
            m_stall4 <= 0;
            m_flush4 <= 0;
        end else begin
            phase <= m_flush_now() ? PH_SHADOW : (m_stall_now() ? PH_HOLD : PH_RUN);
            if (m_stall_now()) begin
                m_stall  <= sat_inc(m_stall, 16);
                m_stall4 <= sat_inc(m_stall4, 4);
            end
            if (m_flush_now()) begin
                m_flush  <= sat_inc(m_flush, 16);
                m_flush4 <= sat_inc(m_flush4, 4);
            end
        end
    end

    always @(negedge clk) begin
        chk("m_fwdA", bus.ForwardA, m_fwd(bus.EX_Rs));
        chk("m_fwdB", bus.ForwardB, m_fwd(bus.EX_Rt));
        chk("m_pc_write", bus.PC_write, !m_stall_now());
        chk("m_if_id_write", bus.IF_ID_Write, !m_stall_now());
        chk("m_bubble", bus.ID_EX_Bubble, m_stall_now());
        chk("m_flushes", {bus.IF_ID_Flush, bus.ID_EX_Flush, bus.EX_MEM_Flush},
            {3{m_flush_now()}});
        chk("m_state", bus.state, phase);
        chk("m_stall_count", bus.stall_count, m_stall);
        chk("m_flush_count", bus.flush_count, m_flush);
        chk("m_state4", bus4.state, phase);
        chk("m_stall_count4", bus4.stall_count, m_stall4);
        chk("m_flush_count4", bus4.flush_count, m_flush4);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.ID_Rs           = 5'd0;
        bus.ID_Rt           = 5'd0;
        bus.EX_Rs           = 5'd0;
        bus.EX_Rt           = 5'd0;
        bus.ID_EX_MemRead   = 1'b0;
        bus.MEM_Rd          = 5'd0;
        bus.EX_MEM_RegWrite = 1'b0;
        bus.WB_Rd           = 5'd0;
        bus.MEM_WB_RegWrite = 1'b0;
        bus.MEM_PCSrc       = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_luh();
        bus.ID_EX_MemRead = 1'b1;
        bus.EX_Rt         = 5'd5;
        bus.ID_Rt         = 5'd5;
    endtask

    initial begin
        clear();
        #1 rst_n = 1'b0;
        #1;
        // Forwarding stays live and control outputs stay quiet while in reset.
        bus.EX_Rs = 5'd3; bus.MEM_Rd = 5'd3; bus.EX_MEM_RegWrite = 1'b1; bus.MEM_PCSrc = 1'b1;
        set_luh();
        #1;
        chk("rst_state", bus.state, 2'b00);
        chk("rst_stall_count", bus.stall_count, 0);
        chk("rst_flush_count", bus.flush_count, 0);
        chk("rst_pc_write", bus.PC_write, 1'b1);
        chk("rst_bubble", bus.ID_EX_Bubble, 1'b0);
        chk("rst_flush", bus.IF_ID_Flush, 1'b0);
        chk("rst_fwdA", bus.ForwardA, 2'b10);
        step();
        clear();
        rst_n = 1'b1;

        // Forwarding priority.
        step();
        bus.EX_Rs = 5'd3; bus.MEM_Rd = 5'd3; bus.EX_MEM_RegWrite = 1'b1;
        bus.WB_Rd = 5'd3; bus.MEM_WB_RegWrite = 1'b1; bus.EX_Rt = 5'd3;
        #1;
        chk("fwdA_exmem", bus.ForwardA, 2'b10);
        chk("fwdB_exmem", bus.ForwardB, 2'b10);
        bus.EX_MEM_RegWrite = 1'b0;
        #1;
        chk("fwdA_memwb", bus.ForwardA, 2'b01);
        bus.MEM_Rd = 5'd0; bus.WB_Rd = 5'd0;
        #1;
        chk("fwdA_none", bus.ForwardA, 2'b00);
        step();
        clear();

        // Load-use stall, then HOLD, then reset asserted mid-HOLD.
        step();
        set_luh();
        #1;
        chk("luh_pc_write", bus.PC_write, 1'b0);
        chk("luh_if_id_write", bus.IF_ID_Write, 1'b0);
        chk("luh_bubble", bus.ID_EX_Bubble, 1'b1);
        step();
        chk("hold_state", bus.state, 2'b10);
        chk("hold_bubble", bus.ID_EX_Bubble, 1'b0);
        chk("hold_pc_write", bus.PC_write, 1'b1);
        chk("hold_stall_count", bus.stall_count, 1);
        rst_n = 1'b0;
        #1;
        chk("midhold_rst_state", bus.state, 2'b00);
        chk("midhold_rst_stall", bus.stall_count, 0);
        chk("midhold_rst_flush", bus.flush_count, 0);
        step();
        rst_n = 1'b1;
        clear();

        // Branch taken together with a load-use hazard.
        step();
        set_luh();
        bus.MEM_PCSrc = 1'b1;
        #1;
        chk("br_flushes", {bus.IF_ID_Flush, bus.ID_EX_Flush, bus.EX_MEM_Flush}, 3'b111);
        chk("br_pc_write", bus.PC_write, 1'b1);
        chk("br_bubble", bus.ID_EX_Bubble, 1'b0);
        step();
        bus.MEM_PCSrc = 1'b0;
        #1;
        chk("br_state", bus.state, 2'b01);
        chk("br_flush_count", bus.flush_count, 1);
        chk("br_stall_count", bus.stall_count, 0);
        chk("shadow_no_bubble", bus.ID_EX_Bubble, 1'b0);
        step();
        clear();
        do_reset();

        // Two back-to-back taken branches.
        step();
        bus.MEM_PCSrc = 1'b1;
        #1;
        chk("br2_flush_a", bus.IF_ID_Flush, 1'b1);
        step();
        chk("br2_state_a", bus.state, 2'b01);
        chk("br2_flush_b", bus.EX_MEM_Flush, 1'b1);
        step();
        bus.MEM_PCSrc = 1'b0;
        chk("br2_state_b", bus.state, 2'b01);
        chk("br2_flush_count", bus.flush_count, 2);
        step();

        // 20 stalls: the 4-bit counter saturates at 15.
        set_luh();
        for (int i = 0; i < 40; i++) step();
        chk("sat_stall16", bus.stall_count, 20);
        chk("sat_stall4", bus4.stall_count, 15);
        clear();

        // Mixed vectors checked only by the model.
        for (int i = 0; i < 24; i++) begin
            step();
            bus.EX_Rs           = 5'(i % 4);
            bus.EX_Rt           = 5'((i / 2) % 4);
            bus.MEM_Rd          = 5'(i % 3);
            bus.WB_Rd           = 5'((i + 1) % 4);
            bus.EX_MEM_RegWrite = 1'((i >> 1) & 1);
            bus.MEM_WB_RegWrite = 1'((i >> 2) & 1);
            bus.ID_EX_MemRead   = 1'((i % 3) != 0);
            bus.ID_Rs           = 5'((i + 2) % 4);
            bus.ID_Rt           = 5'(i % 2);
            bus.MEM_PCSrc       = 1'((i % 5) == 4);
        end
        step();
        clear();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
